noc_input_port: RTL

- Router input-port unit, directly upstream of the per-output 5-way grant-hold arbiters.
- Buffers incoming flits in a small FIFO and XY-routes each head flit.
- Drives a one-hot request to exactly one output arbiter and holds it until the packet tail leaves.
- Forwards flits to the crossbar only while the granted arbiter holds grant.

---
 rtl/noc_pkg.sv | 37 +++
 rtl/noc_flit_fifo.sv | 57 +++++
 rtl/noc_input_port.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - port indices, flit field positions and FSM states for the NoC input port
package noc_pkg;

    // Output port indices, matching bit positions of the req/gnt vectors.
    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_N = 3'd3;
    localparam logic [2:0] PORT_S = 3'd4;
    localparam int         NUM_PORTS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        REQ   = 2'd2,
        XFER  = 2'd3
    } port_state_t;

    // Head flag is the flit MSB, tail flag sits just below it.
    function automatic int flit_head_pos(input int flit_w);
        return flit_w - 1;
    endfunction

    function automatic int flit_tail_pos(input int flit_w);
        return flit_w - 2;
    endfunction

    // Destination X sits directly above destination Y at the bottom of the payload.
    function automatic int flit_dx_lsb(input int y_w);
        return y_w;
    endfunction

    function automatic int flit_dy_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - power-of-two flit FIFO with combinational front entry
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic [FLIT_W-1:0] front,
    output logic              full,
    output logic              empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // Guard the handshakes so an overflow or underflow can never corrupt pointers.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign front   = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - router input port: flit FIFO, XY route, held request; NOC_PORT_STATS_EN adds counters
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W+1:0] in_flit,
    output logic              in_ready,
    output logic [4:0]        req,
    input  logic [4:0]        gnt,
    output logic              out_valid,
    output logic [DATA_W+1:0] out_flit,
    input  logic              out_ready,
    output logic              err_drop
`ifdef NOC_PORT_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int FLIT_W = DATA_W + 2;
    localparam int HEAD_B = flit_head_pos(FLIT_W);
    localparam int TAIL_B = flit_tail_pos(FLIT_W);
    localparam int DX_LSB = flit_dx_lsb(Y_W);
    localparam int DY_LSB = flit_dy_lsb();
    localparam logic [X_W-1:0] HOME_X = MY_X[X_W-1:0];
    localparam logic [Y_W-1:0] HOME_Y = MY_Y[Y_W-1:0];

    port_state_t       state;
    port_state_t       state_nxt;
    logic [2:0]        route;
    logic [2:0]        route_calc;
    logic [FLIT_W-1:0] front;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              fire;
    logic              drop;
    logic              grant_hit;
    logic              req_active;
    logic              front_head;
    logic              front_tail;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_flit),
        .pop       (pop),
        .front     (front),
        .full      (full),
        .empty     (empty)
    );

    assign front_head = front[HEAD_B];
    assign front_tail = front[TAIL_B];
    assign dest_x     = front[DX_LSB +: X_W];
    assign dest_y     = front[DY_LSB +: Y_W];

    // Request depends only on registered state so the arbiter sees a clean level.
    assign req_active = (state == REQ) || (state == XFER);
    assign req        = req_active ? (5'b00001 << route) : 5'b00000;
    assign grant_hit  = |(req & gnt);

    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign out_valid = grant_hit & ~empty;
    assign out_flit  = front;
    assign fire      = out_valid & out_ready;
    assign pop       = fire | drop;
    assign err_drop  = drop;

    // XY dimension-order route of the head flit at the FIFO front.
    always_comb begin
        route_calc = PORT_L;
        if (dest_x > HOME_X)      route_calc = PORT_E;
        else if (dest_x < HOME_X) route_calc = PORT_W;
        else if (dest_y > HOME_Y) route_calc = PORT_N;
        else if (dest_y < HOME_Y) route_calc = PORT_S;
    end

    // Next-state logic; orphan body flits seen in IDLE are discarded here.
    always_comb begin
        state_nxt = state;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (front_head) state_nxt = ROUTE;
                    else            drop      = 1'b1;
                end
            end
            ROUTE: state_nxt = REQ;
            REQ: begin
                if (grant_hit) state_nxt = (fire && front_tail) ? IDLE : XFER;
            end
            XFER: begin
                if (fire && front_tail) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and route registers; the route is captured once per packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            route <= PORT_L;
        end else begin
            state <= state_nxt;
            if (state == ROUTE) route <= route_calc;
        end
    end

`ifdef NOC_PORT_STATS_EN
    // Saturating packet and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (fire && front_tail && pkt_cnt != 16'hFFFF) pkt_cnt  <= pkt_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)              drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
